i2s_transmitter: RTL

- Standalone I2S transmitter: serializes a left/right pair of `d_width`-bit two's-complement samples onto a DAC serial line.
- Generates its own bit clock (`o_sclk`) and word select (`o_ws`) from the master clock.
- Sits between the effect chain's output (left/right TX words) and the DA pins (`da_sclk`, `da_lrck`, `da_sdin`).
- Intended as the dedicated transmit half of the I2S interface, so playback can be clocked and verified independently of the capture path.

---
 rtl/i2s_transmitter.sv | 112 +++++++++++
 1 files changed

// File: rtl/i2s_transmitter.sv
// rtl/i2s_transmitter.sv - standalone I2S transmitter with self-generated sclk/ws
//
// Serializes a left/right pair of two's-complement samples onto an I2S DAC
// line. The bit clock and word select are derived from mclk by counters.
// Samples are captured once per frame into shadow registers, so upstream
// may change its inputs at any time after o_sample_req.
//
// Ports:
//   mclk          master clock, sole clock
//   reset         asynchronous, active-high reset
//   i_l_data      left sample (d_width bits, signed)
//   i_r_data      right sample (d_width bits, signed)
//   o_sclk        serial bit clock, mclk_sclk_ratio mclk per period, 50% duty
//   o_ws          word select, 0 = left slot, 1 = right slot
//   o_sd          serial data, MSB first, one sclk after the ws change
//   o_sample_req  one-mclk pulse when the inputs are latched

module i2s_transmitter #(
  parameter int mclk_sclk_ratio = 4,
  parameter int sclk_ws_ratio   = 64,
  parameter int d_width         = 24
) (
  input  logic               mclk,
  input  logic               reset,
  input  logic [d_width-1:0] i_l_data,
  input  logic [d_width-1:0] i_r_data,
  output logic               o_sclk,
  output logic               o_ws,
  output logic               o_sd,
  output logic               o_sample_req
);

  localparam int MCW  = (mclk_sclk_ratio > 2) ? $clog2(mclk_sclk_ratio) : 1;
  localparam int BW   = $clog2(sclk_ws_ratio);
  localparam int IW   = (d_width > 1) ? $clog2(d_width) : 1;
  localparam int HALF = sclk_ws_ratio / 2;

  logic [MCW-1:0]     mclk_cnt_q, mclk_cnt_d;
  logic [BW-1:0]      bit_cnt_q, bit_cnt_d;
  logic [d_width-1:0] l_sh_q, l_sh_d;
  logic [d_width-1:0] r_sh_q, r_sh_d;
  logic               sclk_q, sclk_d;
  logic               ws_q, ws_d;
  logic               sd_q, sd_d;
  logic               req_q, req_d;

  logic               fall;
  logic               wrap;
  logic [BW-1:0]      pos;
  logic [IW-1:0]      sd_idx;
  logic [d_width-1:0] word;

  always_comb begin
    fall = (mclk_cnt_q == MCW'(mclk_sclk_ratio - 1));
    wrap = fall && (bit_cnt_q == BW'(sclk_ws_ratio - 1));

    mclk_cnt_d = fall ? '0 : mclk_cnt_q + 1'b1;

    bit_cnt_d = bit_cnt_q;
    if (fall) begin
      bit_cnt_d = wrap ? '0 : bit_cnt_q + 1'b1;
    end

    l_sh_d = wrap ? i_l_data : l_sh_q;
    r_sh_d = wrap ? i_r_data : r_sh_q;

    // All outputs are computed from next-state values so the registered
    // outputs line up with the counters they are derived from.
    sclk_d = (mclk_cnt_d >= MCW'(mclk_sclk_ratio / 2));
    ws_d   = (bit_cnt_d >= BW'(HALF));
    pos    = ws_d ? (bit_cnt_d - BW'(HALF)) : bit_cnt_d;
    word   = ws_d ? r_sh_d : l_sh_d;

    // Slot position 1 carries the MSB; position 0 is the I2S one-bit delay
    // and positions past d_width are zero padding.
    sd_idx = IW'(BW'(d_width) - pos);
    sd_d   = 1'b0;
    if ((pos != '0) && (pos <= BW'(d_width))) begin
      sd_d = word[sd_idx];
    end

    req_d = wrap;
  end

  always_ff @(posedge mclk or posedge reset) begin
    if (reset) begin
      mclk_cnt_q <= '0;
      bit_cnt_q  <= '0;
      l_sh_q     <= '0;
      r_sh_q     <= '0;
      sclk_q     <= 1'b0;
      ws_q       <= 1'b0;
      sd_q       <= 1'b0;
      req_q      <= 1'b0;
    end else begin
      mclk_cnt_q <= mclk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      l_sh_q     <= l_sh_d;
      r_sh_q     <= r_sh_d;
      sclk_q     <= sclk_d;
      ws_q       <= ws_d;
      sd_q       <= sd_d;
      req_q      <= req_d;
    end
  end

  assign o_sclk       = sclk_q;
  assign o_ws         = ws_q;
  assign o_sd         = sd_q;
  assign o_sample_req = req_q;

endmodule
